// File: rtl/tone_voice_mixer.sv
// Multi-voice square/triangle tone generator and mixer handing offset-binary samples to a DAC.
// Defining TONE_VOICE_MIXER_ENVELOPE_EN adds a per-voice linear attack/release gain.
module tone_voice_mixer #(
  parameter int NUM_VOICES = 6,
  parameter int PHASE_W    = 24,
  parameter int AMP_W      = 8,
  parameter int SAMPLE_W   = 12,
  parameter int GAIN_SHIFT = 3
) (
  input  logic                               clock_50Mhz,
  input  logic                               reset,
  input  logic                               sampleTick,
  input  logic [NUM_VOICES-1:0]              voiceEnable,
  input  logic [NUM_VOICES-1:0]              waveSelect,
  input  logic [NUM_VOICES*PHASE_W-1:0]      phaseIncrement,
  input  logic                               dacBusy,
  output logic [SAMPLE_W-1:0]                outputSample,
  output logic                               sampleValid,
  output logic                               overrun,
  output logic [$clog2(NUM_VOICES+1)-1:0]    activeVoices
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = AMP_W + $clog2(NUM_VOICES) + 1;
  localparam int MIX_W = ACC_W + SAMPLE_W - AMP_W;
  localparam int AV_W  = $clog2(NUM_VOICES + 1);
  localparam logic [SAMPLE_W-1:0]    MID     = SAMPLE_W'(1) << (SAMPLE_W - 1);
  localparam logic signed [MIX_W-1:0] SAT_MAX = (MIX_W'(1) << (SAMPLE_W - 1)) - MIX_W'(1);
  localparam logic signed [MIX_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, WAIT_DAC} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SAMPLE_W-1:0]     result_q, result_d;
  logic [SAMPLE_W-1:0]     sample_q, sample_d;
  logic                    overrun_q, overrun_d;
  logic [AV_W-1:0]         active_q, active_d;
  logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]      phase_d [NUM_VOICES];

  logic [NUM_VOICES-1:0][AMP_W-1:0] wave_all;
  logic                    tick_accept, last_voice, cur_en, cur_live;
  logic [PHASE_W-1:0]      cur_phase, cur_inc, next_phase;
  logic signed [AMP_W-1:0] cur_wave, contrib;
  logic [AV_W-1:0]         popcnt;
  logic signed [MIX_W-1:0] mix_up, mix;
  logic [SAMPLE_W-1:0]     sat;

  // Per-voice waveform from the phase held before this frame's update.
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_wave
    logic             msb;
    logic [AMP_W:0]   tri_p;
    logic [AMP_W-1:0] tri_t;
    assign msb          = phase_q[gi][PHASE_W-1];
    assign tri_p        = phase_q[gi][PHASE_W-1 -: AMP_W+1];
    assign tri_t        = tri_p[AMP_W] ? ~tri_p[AMP_W-1:0] : tri_p[AMP_W-1:0];
    assign wave_all[gi] = waveSelect[gi] ? {~tri_t[AMP_W-1], tri_t[AMP_W-2:0]}
                                         : {msb, {(AMP_W-1){~msb}}};
  end

  assign tick_accept = (state_q == IDLE) && sampleTick;
  assign last_voice  = (int'(idx_q) == NUM_VOICES - 1);

`ifdef TONE_VOICE_MIXER_ENVELOPE_EN
  logic [4:0]              gain_q [NUM_VOICES];
  logic [4:0]              gain_d [NUM_VOICES];
  logic [4:0]              cur_gain;
  logic signed [AMP_W+5:0] env_prod;

  assign env_prod = (AMP_W+6)'(cur_wave) * (AMP_W+6)'($signed({1'b0, cur_gain}));
  assign contrib  = env_prod[AMP_W+3:4];
  // A fading voice keeps running until its gain reaches zero.
  assign cur_live = cur_en || (cur_gain != 5'd0);

  always_comb begin : p_gain
    for (int i = 0; i < NUM_VOICES; i++) begin
      gain_d[i] = gain_q[i];
      if (tick_accept) begin
        if (voiceEnable[i]) begin
          if (gain_q[i] != 5'd16) gain_d[i] = gain_q[i] + 5'd1;
        end else if (gain_q[i] != 5'd0) begin
          gain_d[i] = gain_q[i] - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_50Mhz) begin : p_gain_reg
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (reset) gain_q[i] <= 5'd0;
      else       gain_q[i] <= gain_d[i];
    end
  end
`else
  assign contrib  = cur_en ? cur_wave : '0;
  assign cur_live = cur_en;
`endif

  always_comb begin : p_select
    cur_phase = '0;
    cur_inc   = '0;
    cur_en    = 1'b0;
    cur_wave  = '0;
`ifdef TONE_VOICE_MIXER_ENVELOPE_EN
    cur_gain  = '0;
`endif
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (int'(idx_q) == i) begin
        cur_phase = phase_q[i];
        cur_inc   = phaseIncrement[i*PHASE_W +: PHASE_W];
        cur_en    = voiceEnable[i];
        cur_wave  = wave_all[i];
`ifdef TONE_VOICE_MIXER_ENVELOPE_EN
        cur_gain  = gain_q[i];
`endif
      end
    end
  end

  assign next_phase = cur_live ? cur_phase + cur_inc : '0;

  always_comb begin : p_phase
    for (int i = 0; i < NUM_VOICES; i++) begin
      phase_d[i] = phase_q[i];
      if ((state_q == ACCUM) && (int'(idx_q) == i)) phase_d[i] = next_phase;
    end
  end

  always_comb begin : p_popcount
    popcnt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
`ifdef TONE_VOICE_MIXER_ENVELOPE_EN
      if (gain_d[i] != 5'd0) popcnt = popcnt + AV_W'(1);
`else
      if (voiceEnable[i]) popcnt = popcnt + AV_W'(1);
`endif
    end
  end

  assign mix_up = MIX_W'(acc_q) <<< (SAMPLE_W - AMP_W);
  assign mix    = mix_up >>> GAIN_SHIFT;

  always_comb begin : p_saturate
    sat = mix[SAMPLE_W-1:0];
    if (mix > SAT_MAX)      sat = SAT_MAX[SAMPLE_W-1:0];
    else if (mix < SAT_MIN) sat = SAT_MIN[SAMPLE_W-1:0];
  end

  always_ff @(posedge clock_50Mhz) begin : p_state_reg
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      IDLE:     if (sampleTick) state_d = ACCUM;
      ACCUM:    if (last_voice) state_d = SCALE;
      SCALE:    state_d = WAIT_DAC;
      WAIT_DAC: if (!dacBusy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin : p_datapath
    idx_d     = idx_q;
    acc_d     = acc_q;
    result_d  = result_q;
    sample_d  = sample_q;
    active_d  = active_q;
    overrun_d = sampleTick && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (tick_accept) begin
          idx_d    = '0;
          acc_d    = '0;
          active_d = popcnt;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_W'(contrib);
        idx_d = last_voice ? '0 : idx_q + IDX_W'(1);
      end
      // Offset binary is the two's-complement value with its MSB inverted.
      SCALE:    result_d = {~sat[SAMPLE_W-1], sat[SAMPLE_W-2:0]};
      WAIT_DAC: if (!dacBusy) sample_d = result_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock_50Mhz) begin : p_data_reg
    if (reset) begin
      idx_q     <= '0;
      acc_q     <= '0;
      result_q  <= MID;
      sample_q  <= MID;
      overrun_q <= 1'b0;
      active_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else begin
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
      active_q  <= active_d;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= phase_d[i];
    end
  end

  // The strobe cycle presents the new sample directly so it is valid alongside sampleValid.
  always_comb begin : p_output
    sampleValid  = (state_q == WAIT_DAC) && !dacBusy && !reset;
    outputSample = sampleValid ? result_q : sample_q;
    overrun      = overrun_q;
    activeVoices = active_q;
  end

endmodule

// File: tb/tb_tone_voice_mixer.sv
// Bench for tone_voice_mixer: constant vector table, hand-written corner sequences, and
// randomized frames checked against an arithmetic reference model.
module tb_tone_voice_mixer;
  localparam int NV = 6;
  localparam int PW = 24;
  localparam int SW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, sampleTick, dacBusy;
  logic [NV-1:0]    voiceEnable, waveSelect;
  logic [NV*PW-1:0] phaseIncrement;
  logic [SW-1:0]    outputSample, outputSample_g0;
  logic             sampleValid, sampleValid_g0, overrun, overrun_g0;
  logic [2:0]       activeVoices, activeVoices_g0;

  tone_voice_mixer dut (
    .clock_50Mhz(clk), .reset(reset), .sampleTick(sampleTick),
    .voiceEnable(voiceEnable), .waveSelect(waveSelect), .phaseIncrement(phaseIncrement),
    .dacBusy(dacBusy), .outputSample(outputSample), .sampleValid(sampleValid),
    .overrun(overrun), .activeVoices(activeVoices)
  );

  tone_voice_mixer #(.GAIN_SHIFT(0)) dut_g0 (
    .clock_50Mhz(clk), .reset(reset), .sampleTick(sampleTick),
    .voiceEnable(voiceEnable), .waveSelect(waveSelect), .phaseIncrement(phaseIncrement),
    .dacBusy(dacBusy), .outputSample(outputSample_g0), .sampleValid(sampleValid_g0),
    .overrun(overrun_g0), .activeVoices(activeVoices_g0)
  );

  typedef struct {
    logic [5:0] en;
    logic [5:0] ws;
    int         inc0;
    int         exp_s;
    int         exp_av;
  } vec_t;

  vec_t   vecs[12];
  int     total = 0;
  int     bad = 0;
  longint m_phase[NV];
  int     m_gain[NV];
  int     m_inc[NV];
  int     ov_cnt, sv_cnt, last_sample;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_watch();
    step();
    ov_cnt += int'(overrun);
    if (sampleValid) begin
      sv_cnt++;
      last_sample = int'(outputSample);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if (((a % b) != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int scale(input int sum, input int sh);
    int m;
    m = fdiv(sum * 16, 1 << sh);
    if (m > 2047) m = 2047;
    if (m < -2048) m = -2048;
    return m + 2048;
  endfunction

  task automatic drive_inc();
    for (int i = 0; i < NV; i++) phaseIncrement[i*PW +: PW] = PW'(m_inc[i]);
  endtask

  task automatic set_inc(input int inc0, input int inc_rest);
    for (int i = 0; i < NV; i++) m_inc[i] = (i == 0) ? inc0 : inc_rest;
    drive_inc();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_phase[i] = 0;
      m_gain[i]  = 0;
    end
  endtask

  // Reference: one accepted tick, using the inputs currently driven.
  task automatic model_tick(output int es, output int eg, output int ea);
    int  sum, wave, p, t, cnt;
    bit  live;
    sum = 0;
    cnt = 0;
    for (int i = 0; i < NV; i++) begin
`ifdef TONE_VOICE_MIXER_ENVELOPE_EN
      if (voiceEnable[i]) m_gain[i] = (m_gain[i] < 16) ? m_gain[i] + 1 : 16;
      else                m_gain[i] = (m_gain[i] > 0) ? m_gain[i] - 1 : 0;
      if (m_gain[i] > 0) cnt++;
`else
      if (voiceEnable[i]) cnt++;
`endif
    end
    for (int i = 0; i < NV; i++) begin
      if (waveSelect[i]) begin
        p    = int'(m_phase[i] / 32768);
        t    = (p < 256) ? p : 511 - p;
        wave = t - 128;
      end else begin
        wave = (m_phase[i] < 64'd8388608) ? 127 : -128;
      end
`ifdef TONE_VOICE_MIXER_ENVELOPE_EN
      sum += fdiv(wave * m_gain[i], 16);
      live = voiceEnable[i] || (m_gain[i] > 0);
`else
      if (voiceEnable[i]) sum += wave;
      live = voiceEnable[i];
`endif
      if (live) m_phase[i] = (m_phase[i] + longint'(m_inc[i])) % 64'd16777216;
      else      m_phase[i] = 0;
    end
    es = scale(sum, 3);
    eg = scale(sum, 0);
    ea = cnt;
  endtask

  task automatic frame(input string name, input int exp_s, input int exp_g,
                       input int exp_av, input bit chk_g);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    sampleTick = 1'b1;
    while (!seen && n < 64) begin
      step();
      n++;
      sampleTick = 1'b0;
      if (sampleValid) seen = 1'b1;
    end
    chk({name, "_seen"}, int'(seen), 1);
    chk({name, "_latency"}, n, 8);
    chk({name, "_sample"}, int'(outputSample), exp_s);
    if (chk_g) chk({name, "_sample_g0"}, int'(outputSample_g0), exp_g);
    chk({name, "_active"}, int'(activeVoices), exp_av);
    $display("frame %s: sample=%0d g0=%0d lat=%0d active=%0d",
             name, outputSample, outputSample_g0, n, activeVoices);
    step();
    chk({name, "_single_strobe"}, int'(sampleValid), 0);
  endtask

  task automatic model_frame(input string name);
    int es, eg, ea;
    model_tick(es, eg, ea);
    frame(name, es, eg, ea, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int es, eg, ea, n, prev, changed, p, t;

    vecs[0] = '{6'b000001, 6'b000000, 1 << 23, 2302, 1};
    vecs[1] = '{6'b000001, 6'b000000, 1 << 23, 1792, 1};
    vecs[2] = '{6'b000001, 6'b000000, 1 << 23, 2302, 1};
    vecs[3] = '{6'b000001, 6'b000000, 1 << 23, 1792, 1};
    for (int i = 4; i < 12; i++) vecs[i] = '{6'b000000, 6'b000000, 1 << 23, 2048, 0};

    reset = 1'b1; sampleTick = 1'b0; dacBusy = 1'b0;
    voiceEnable = '0; waveSelect = '0; phaseIncrement = '0;
    model_reset();
    ov_cnt = 0; sv_cnt = 0; last_sample = 0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_sample", int'(outputSample), 2048);
    chk("rst_valid", int'(sampleValid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_active", int'(activeVoices), 0);

`ifndef TONE_VOICE_MIXER_ENVELOPE_EN
    for (int i = 0; i < 12; i++) begin
      voiceEnable = vecs[i].en;
      waveSelect  = vecs[i].ws;
      set_inc(vecs[i].inc0, 0);
      model_tick(es, eg, ea);
      frame($sformatf("vec%0d", i), vecs[i].exp_s, eg, vecs[i].exp_av, 1'b0);
    end
    for (int i = 0; i < NV; i++)
      chk($sformatf("phase%0d_zero", i), int'(dut.phase_q[i]), 0);

    voiceEnable = 6'h3F; waveSelect = 6'h00;
    set_inc(0, 0);
    for (int k = 0; k < 2; k++) begin
      model_tick(es, eg, ea);
      frame($sformatf("sat%0d", k), 3572, 4095, 6, 1'b1);
    end

    voiceEnable = 6'h01; waveSelect = 6'h01;
    set_inc(1 << 15, 0);
    for (int k = 0; k <= 512; k++) begin
      p = k % 512;
      t = (p < 256) ? p : 511 - p;
      model_tick(es, eg, ea);
      frame($sformatf("tri%0d", k), 2048 + 2 * (t - 128), eg, 1, 1'b1);
    end
`endif

    // Second tick during ACCUM is dropped.
    voiceEnable = 6'b000011; waveSelect = 6'b000010;
    set_inc(1 << 23, 1 << 20);
    model_tick(es, eg, ea);
    ov_cnt = 0; sv_cnt = 0; last_sample = -1;
    sampleTick = 1'b1; step_watch(); sampleTick = 1'b0;
    step_watch(); step_watch();
    sampleTick = 1'b1; step_watch(); sampleTick = 1'b0;
    repeat (30) step_watch();
    chk("ovr_pulses", ov_cnt, 1);
    chk("ovr_valids", sv_cnt, 1);
    chk("ovr_sample", last_sample, es);
    $display("overrun seq: overrun=%0d valids=%0d sample=%0d", ov_cnt, sv_cnt, last_sample);

    // Tick on the cycle the FSM returns to IDLE is dropped.
    model_tick(es, eg, ea);
    ov_cnt = 0; sv_cnt = 0; n = 0;
    sampleTick = 1'b1; step_watch(); sampleTick = 1'b0;
    while (sv_cnt == 0 && n < 40) begin
      step_watch();
      n++;
    end
    chk("ret_seen", sv_cnt, 1);
    chk("ret_sample", int'(outputSample), es);
    ov_cnt = 0; sv_cnt = 0;
    sampleTick = 1'b1; step_watch(); sampleTick = 1'b0;
    repeat (20) step_watch();
    chk("ret_overrun", ov_cnt, 1);
    chk("ret_no_frame", sv_cnt, 0);
    $display("return-tick seq: overrun=%0d valids=%0d", ov_cnt, sv_cnt);

    // DAC busy stalls the hand-off.
    voiceEnable = 6'b000101; waveSelect = 6'b000100;
    set_inc(1 << 22, 1 << 21);
    model_tick(es, eg, ea);
    prev = int'(outputSample);
    dacBusy = 1'b1; changed = 0; sv_cnt = 0;
    sampleTick = 1'b1; step_watch(); sampleTick = 1'b0;
    repeat (20) begin
      step_watch();
      if (int'(outputSample) != prev) changed++;
    end
    chk("busy_no_valid", sv_cnt, 0);
    chk("busy_hold", changed, 0);
    dacBusy = 1'b0;
    #1;
    chk("busy_release_valid", int'(sampleValid), 1);
    chk("busy_release_sample", int'(outputSample), es);
    chk("busy_release_g0", int'(outputSample_g0), eg);
    step();
    chk("busy_single_strobe", int'(sampleValid), 0);
    $display("busy seq: sample=%0d", outputSample);

    for (int k = 0; k < 40; k++) begin
      voiceEnable = 6'($urandom);
      waveSelect  = 6'($urandom);
      for (int i = 0; i < NV; i++) m_inc[i] = int'($urandom_range(0, 24'hFFFFFF));
      drive_inc();
      model_frame($sformatf("rnd%0d", k));
    end

    // Reset during ACCUM index 2 aborts the frame.
    voiceEnable = 6'b000111; waveSelect = 6'b000000;
    set_inc(1 << 23, 1 << 22);
    sv_cnt = 0;
    sampleTick = 1'b1; step_watch(); sampleTick = 1'b0;
    step_watch(); step_watch();
    reset = 1'b1; step_watch(); reset = 1'b0;
    model_reset();
    chk("midrst_sample", int'(outputSample), 2048);
    chk("midrst_valid", int'(sampleValid), 0);
    chk("midrst_active", int'(activeVoices), 0);
    repeat (15) step_watch();
    chk("midrst_no_valid", sv_cnt, 0);
    $display("mid-frame reset: valids=%0d sample=%0d", sv_cnt, outputSample);
    voiceEnable = 6'b000001;
    set_inc(1 << 23, 0);
    model_frame("post_reset");

`ifdef TONE_VOICE_MIXER_ENVELOPE_EN
    for (int k = 0; k < 20; k++) model_frame($sformatf("env_up%0d", k));
    voiceEnable = 6'b000000;
    for (int k = 0; k < 18; k++) model_frame($sformatf("env_dn%0d", k));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
